multicycle_control: RTL and testbench

//  Main FSM of the multi-cycle TSC CPU. Sequences the shared 16-bit ALU, register file, PC, IR and memory port through IF/ID/EX/MEM/WB/HALT.

---
 rtl/multicycle_control_pkg.sv | 85 ++++++++
 rtl/inst_class_decoder.sv | 36 +++
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle TSC control unit: ISA opcodes/funcs, ALU op codes,
// FSM state encoding, datapath mux select codes and the instruction class vector.
package multicycle_control_pkg;

   localparam int unsigned WORD_SIZE = 16;
   localparam int unsigned ALU_OP_W  = 6;

   // Instruction opcodes (IR[15:12])
   localparam logic [3:0] OpBne   = 4'd0;
   localparam logic [3:0] OpBeq   = 4'd1;
   localparam logic [3:0] OpBgz   = 4'd2;
   localparam logic [3:0] OpBlz   = 4'd3;
   localparam logic [3:0] OpAdi   = 4'd4;
   localparam logic [3:0] OpOri   = 4'd5;
   localparam logic [3:0] OpLhi   = 4'd6;
   localparam logic [3:0] OpLwd   = 4'd7;
   localparam logic [3:0] OpSwd   = 4'd8;
   localparam logic [3:0] OpJmp   = 4'd9;
   localparam logic [3:0] OpJal   = 4'd10;
   localparam logic [3:0] OpRtype = 4'd15;

   // R-type instruction funcs outside the plain ALU range 0-7
   localparam logic [5:0] InstJpr = 6'd25;
   localparam logic [5:0] InstJrl = 6'd26;
   localparam logic [5:0] InstWwd = 6'd28;
   localparam logic [5:0] InstHlt = 6'd29;

   // ALU operation codes; 0-7 coincide with the R-type func field
   localparam logic [ALU_OP_W-1:0] FuncAdd = 6'd0;
   localparam logic [ALU_OP_W-1:0] FuncAdi = 6'd8;
   localparam logic [ALU_OP_W-1:0] FuncOri = 6'd9;
   localparam logic [ALU_OP_W-1:0] FuncLhi = 6'd10;
   localparam logic [ALU_OP_W-1:0] FuncLwd = 6'd11;
   localparam logic [ALU_OP_W-1:0] FuncSwd = 6'd12;
   localparam logic [ALU_OP_W-1:0] FuncA   = 6'd13;

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd5
   } state_e;

   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;

   localparam logic [1:0] SrcBRt  = 2'd0;
   localparam logic [1:0] SrcBOne = 2'd1;
   localparam logic [1:0] SrcBImm = 2'd2;

   localparam logic [1:0] RegDstRt = 2'd0;
   localparam logic [1:0] RegDstRd = 2'd1;
   localparam logic [1:0] RegDstR2 = 2'd2;

   localparam logic [1:0] MemToRegAluOut = 2'd0;
   localparam logic [1:0] MemToRegMdr    = 2'd1;
   localparam logic [1:0] MemToRegPc     = 2'd2;

   typedef struct packed {
      logic ralu;
      logic imm;
      logic lwd;
      logic swd;
      logic br;
      logic jmp;
      logic jal;
      logic jpr;
      logic jrl;
      logic wwd;
      logic hlt;
      logic ill;
   } inst_class_t;

   function automatic logic [ALU_OP_W-1:0] imm_alu_op(input logic [3:0] op);
      case (op)
         OpOri:   imm_alu_op = FuncOri;
         OpLhi:   imm_alu_op = FuncLhi;
         default: imm_alu_op = FuncAdi;
      endcase
   endfunction

endpackage

// File: rtl/inst_class_decoder.sv
// Combinational decode of opcode/func into a one-hot instruction class.
module inst_class_decoder
   import multicycle_control_pkg::*;
(
   input  logic [3:0]  opcode,
   input  logic [5:0]  func_code,
   output inst_class_t inst_class
);

   always_comb begin
      inst_class = '0;
      case (opcode)
         OpBne, OpBeq, OpBgz, OpBlz: inst_class.br  = 1'b1;
         OpAdi, OpOri, OpLhi:        inst_class.imm = 1'b1;
         OpLwd:                      inst_class.lwd = 1'b1;
         OpSwd:                      inst_class.swd = 1'b1;
         OpJmp:                      inst_class.jmp = 1'b1;
         OpJal:                      inst_class.jal = 1'b1;
         OpRtype: begin
            if (func_code[5:3] == 3'b000) begin
               inst_class.ralu = 1'b1;
            end else begin
               case (func_code)
                  InstJpr: inst_class.jpr = 1'b1;
                  InstJrl: inst_class.jrl = 1'b1;
                  InstWwd: inst_class.wwd = 1'b1;
                  InstHlt: inst_class.hlt = 1'b1;
                  default: inst_class.ill = 1'b1;
               endcase
            end
         end
         default: inst_class.ill = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main FSM of the multi-cycle TSC CPU (IF/ID/EX/MEM/WB/HALT) with combinational output decode.
// Define INST_COUNT_EN to add the num_inst retired-instruction counter output.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [3:0]          opcode,
   input  logic [5:0]          func_code,
   input  logic                bcond,
   input  logic                inputReady,
   output logic                readM,
   output logic                writeM,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [1:0]          pc_source,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                wwd,
   output logic                is_halted
`ifdef INST_COUNT_EN
   ,
   output logic [WORD_SIZE-1:0] num_inst
`endif
);

   state_e      state_q, state_d;
   inst_class_t cls;

   // The branch decision is applied in the datapath through pc_write_cond.
   logic unused_bcond;
   assign unused_bcond = bcond;

   inst_class_decoder u_decoder (
      .opcode     (opcode),
      .func_code  (func_code),
      .inst_class (cls)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIf;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      readM         = 1'b0;
      writeM        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PcSrcAlu;
      alu_src_a     = 1'b0;
      alu_src_b     = SrcBRt;
      alu_op        = FuncAdd;
      reg_write     = 1'b0;
      reg_dst       = RegDstRt;
      mem_to_reg    = MemToRegAluOut;
      wwd           = 1'b0;
      is_halted     = 1'b0;
      // Outputs are forced low while reset is asserted, even mid-access.
      if (reset_n) begin
         unique case (state_q)
            StIf: begin
               readM = 1'b1;
               if (inputReady) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  alu_op    = FuncAdd;
                  alu_src_b = SrcBOne;
                  pc_source = PcSrcAlu;
                  state_d   = StId;
               end
            end
            StId: begin
               alu_op    = FuncAdi;
               alu_src_b = SrcBImm;
               if (cls.hlt) begin
                  state_d = StHalt;
               end else if (cls.jmp) begin
                  pc_write  = 1'b1;
                  pc_source = PcSrcJump;
                  state_d   = StIf;
               end else if (cls.jal) begin
                  // PC already holds the return address here.
                  pc_write   = 1'b1;
                  pc_source  = PcSrcJump;
                  reg_write  = 1'b1;
                  reg_dst    = RegDstR2;
                  mem_to_reg = MemToRegPc;
                  state_d    = StIf;
               end else if (cls.ill) begin
                  state_d = StIf;
               end else begin
                  state_d = StEx;
               end
            end
            StEx: begin
               alu_src_a = 1'b1;
               state_d   = StIf;
               if (cls.ralu) begin
                  alu_op    = func_code;
                  alu_src_b = SrcBRt;
                  state_d   = StWb;
               end else if (cls.imm) begin
                  alu_op    = imm_alu_op(opcode);
                  alu_src_b = SrcBImm;
                  state_d   = StWb;
               end else if (cls.lwd || cls.swd) begin
                  alu_op    = cls.lwd ? FuncLwd : FuncSwd;
                  alu_src_b = SrcBImm;
                  state_d   = StMem;
               end else if (cls.br) begin
                  pc_write_cond = 1'b1;
                  pc_source     = PcSrcAluOut;
               end else if (cls.jpr || cls.jrl) begin
                  alu_op    = FuncA;
                  pc_write  = 1'b1;
                  pc_source = PcSrcAlu;
                  if (cls.jrl) begin
                     reg_write  = 1'b1;
                     reg_dst    = RegDstR2;
                     mem_to_reg = MemToRegPc;
                  end
               end else if (cls.wwd) begin
                  wwd = 1'b1;
               end
            end
            StMem: begin
               i_or_d = 1'b1;
               readM  = cls.lwd;
               writeM = cls.swd;
               if (inputReady) begin
                  state_d = cls.lwd ? StWb : StIf;
               end
            end
            StWb: begin
               reg_write = 1'b1;
               if (cls.ralu) begin
                  reg_dst = RegDstRd;
               end else if (cls.lwd) begin
                  mem_to_reg = MemToRegMdr;
               end
               state_d = StIf;
            end
            StHalt: begin
               is_halted = 1'b1;
            end
            default: begin
               state_d = StIf;
            end
         endcase
      end
   end

`ifdef INST_COUNT_EN
   logic [WORD_SIZE-1:0] num_inst_q;
   logic                 retire;

   assign retire = ((state_q != StIf) && (state_d == StIf)) ||
                   ((state_q != StHalt) && (state_d == StHalt));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         num_inst_q <= '0;
      end else if (retire) begin
         num_inst_q <= num_inst_q + WORD_SIZE'(1);
      end
   end

   assign num_inst = num_inst_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected controls, a
// negedge monitor pops and compares. Define INST_COUNT_EN to also check num_inst.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] opcode;
   logic [5:0] func_code;
   logic       bcond;
   logic       inputReady;
   logic       readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [5:0] alu_op;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       wwd;
   logic       is_halted;
   logic [15:0] num_inst_w;

`ifdef INST_COUNT_EN
   logic [15:0] num_inst;
   assign num_inst_w = num_inst;
`else
   assign num_inst_w = 16'h0;
`endif

   multicycle_control dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .func_code     (func_code),
      .bcond         (bcond),
      .inputReady    (inputReady),
      .readM         (readM),
      .writeM        (writeM),
      .i_or_d        (i_or_d),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_source     (pc_source),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .wwd           (wwd),
      .is_halted     (is_halted)
`ifdef INST_COUNT_EN
      ,
      .num_inst      (num_inst)
`endif
   );

   always #5 clk = ~clk;

   // {readM,writeM,i_or_d,ir_write,pc_write,pc_write_cond,pc_source,alu_src_a,alu_src_b,
   //  alu_op,reg_write,reg_dst,mem_to_reg,wwd,is_halted}
   logic [23:0] act;
   assign act = {readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                 alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, wwd, is_halted};

   localparam logic [23:0] RM   = 24'h800000;
   localparam logic [23:0] WM   = 24'h400000;
   localparam logic [23:0] IOD  = 24'h200000;
   localparam logic [23:0] IRW  = 24'h100000;
   localparam logic [23:0] PCW  = 24'h080000;
   localparam logic [23:0] PCWC = 24'h040000;
   localparam logic [23:0] SA   = 24'h008000;
   localparam logic [23:0] RW   = 24'h000040;
   localparam logic [23:0] WWDB = 24'h000002;
   localparam logic [23:0] HLTB = 24'h000001;

   function automatic logic [23:0] ps(input int x);  return 24'(x) << 16; endfunction
   function automatic logic [23:0] sb(input int x);  return 24'(x) << 13; endfunction
   function automatic logic [23:0] op(input int x);  return 24'(x) << 7;  endfunction
   function automatic logic [23:0] rd(input int x);  return 24'(x) << 4;  endfunction
   function automatic logic [23:0] mr(input int x);  return 24'(x) << 2;  endfunction

   typedef struct {
      logic [23:0] ctl;
      logic [15:0] ni;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] ni = 16'h0;

   task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h required %h", nm, got, want);
      end
   endtask

   task automatic chk_ni(input string nm, input logic [15:0] got, input logic [15:0] want);
`ifdef INST_COUNT_EN
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s num_inst: got %0d required %0d", nm, got, want);
      end
`endif
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, act, e.ctl);
         chk_ni(e.name, num_inst_w, e.ni);
      end
   end

   task automatic load(input logic [15:0] w);
      opcode    = w[15:12];
      func_code = w[5:0];
   endtask

   // Called at posedge+1: drives one cycle and queues its expected controls.
   task automatic cyc(input logic rdy, input logic bc, input logic [23:0] ctl,
                      input string nm, input bit retire);
      inputReady = rdy;
      bcond      = bc;
      q.push_back('{ctl, ni, nm});
      @(posedge clk);
      #1;
      if (retire) ni = ni + 16'h1;
   endtask

   localparam logic [23:0] IF_W = RM;
   localparam logic [23:0] IF_R = RM | IRW | PCW | (24'd1 << 13);
   localparam logic [23:0] ID_N = (24'd8 << 7) | (24'd2 << 13);

   initial begin
      reset_n    = 1'b0;
      opcode     = 4'h0;
      func_code  = 6'h0;
      bcond      = 1'b0;
      inputReady = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_outputs", act, 24'h0);
      chk_ni("reset", num_inst_w, 16'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset asserted mid-fetch
      cyc(0, 0, IF_W, "if_wait_pre_reset", 0);
      inputReady = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_reset_readM", act, RM);
      reset_n = 1'b0;
      #1;
      chk("mid_fetch_reset", act, 24'h0);
      chk_ni("mid_fetch_reset", num_inst_w, 16'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // ADD
      load(16'hF1C0);
      cyc(1, 0, IF_R,          "add_if", 0);
      cyc(1, 0, ID_N,          "add_id", 0);
      cyc(1, 0, SA,            "add_ex", 0);
      cyc(1, 0, RW | rd(1),    "add_wb", 1);

      // LWD with 2 IF and 3 MEM wait cycles
      load(16'h7106);
      cyc(0, 0, IF_W,                     "lwd_if_w0", 0);
      cyc(0, 0, IF_W,                     "lwd_if_w1", 0);
      cyc(1, 0, IF_R,                     "lwd_if", 0);
      cyc(1, 0, ID_N,                     "lwd_id", 0);
      cyc(1, 0, SA | op(11) | sb(2),      "lwd_ex", 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, RM | IOD, "lwd_mem_wait", 0);
      cyc(1, 0, RM | IOD,                 "lwd_mem", 0);
      cyc(1, 0, RW | mr(1),               "lwd_wb", 1);

      // BEQ taken and not taken
      load(16'h1102);
      cyc(1, 1, IF_R,                    "beq1_if", 0);
      cyc(1, 1, ID_N,                    "beq1_id", 0);
      cyc(1, 1, SA | PCWC | ps(1),       "beq1_ex", 1);
      cyc(1, 0, IF_R,                    "beq0_if", 0);
      cyc(1, 0, ID_N,                    "beq0_id", 0);
      cyc(1, 0, SA | PCWC | ps(1),       "beq0_ex", 1);

      // SWD
      load(16'h8106);
      cyc(1, 0, IF_R,                    "swd_if", 0);
      cyc(1, 0, ID_N,                    "swd_id", 0);
      cyc(1, 0, SA | op(12) | sb(2),     "swd_ex", 0);
      cyc(0, 0, WM | IOD,                "swd_mem_wait", 0);
      cyc(1, 0, WM | IOD,                "swd_mem", 1);

      // ORI
      load(16'h5105);
      cyc(1, 0, IF_R,                    "ori_if", 0);
      cyc(1, 0, ID_N,                    "ori_id", 0);
      cyc(1, 0, SA | op(9) | sb(2),      "ori_ex", 0);
      cyc(1, 0, RW,                      "ori_wb", 1);

      // JRL
      load(16'hF01A);
      cyc(1, 0, IF_R,                                         "jrl_if", 0);
      cyc(1, 0, ID_N,                                         "jrl_id", 0);
      cyc(1, 0, SA | op(13) | PCW | RW | rd(2) | mr(2),       "jrl_ex", 1);

      // JAL
      load(16'hA123);
      cyc(1, 0, IF_R,                                         "jal_if", 0);
      cyc(1, 0, ID_N | PCW | ps(2) | RW | rd(2) | mr(2),      "jal_id", 1);

      // Illegal opcode and illegal func
      load(16'hB000);
      cyc(1, 0, IF_R, "ill_op_if", 0);
      cyc(1, 0, ID_N, "ill_op_id", 1);
      load(16'hF03F);
      cyc(1, 0, IF_R, "ill_func_if", 0);
      cyc(1, 0, ID_N, "ill_func_id", 1);

      // WWD then HLT
      load(16'hF01C);
      cyc(1, 0, IF_R,        "wwd_if", 0);
      cyc(1, 0, ID_N,        "wwd_id", 0);
      cyc(1, 0, SA | WWDB,   "wwd_ex", 1);
      load(16'hF01D);
      cyc(1, 0, IF_R,        "hlt_if", 0);
      cyc(1, 0, ID_N,        "hlt_id", 1);
      for (int i = 0; i < 20; i++) cyc(i[0], 0, HLTB, "halted", 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
